gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 102 ++++++++++
 tb/tb_gshare_predictor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: the PC is XORed with the speculative global history to index
// a PHT of 2-bit counters. In-order checkpoints recover the history after a misprediction.
module gshare_predictor #(
  parameter int GHR_W      = 12,
  parameter int CKPT_DEPTH = 8,
  localparam int TAG_W     = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [TAG_W-1:0] pred_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic             res_mispredict,
  output logic             res_error
);

  localparam int unsigned PHT_N = 1 << GHR_W;
  localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(CKPT_DEPTH);

  typedef struct packed {
    logic [GHR_W-1:0] ghr_before;
    logic [GHR_W-1:0] pht_idx;
  } ckpt_t;

  logic [GHR_W-1:0] ghr_spec;
  logic [1:0]       pht [PHT_N];
  ckpt_t            fifo [CKPT_DEPTH];
  logic [TAG_W-1:0] wr_ptr, rd_ptr;
  logic [TAG_W:0]   count;

  logic [GHR_W-1:0] idx;
  logic [1:0]       pht_rd;
  ckpt_t            head;
  logic [1:0]       ctr, ctr_next;
  logic             accept, res_ok, flush;

  always_comb begin
    idx        = pred_pc[GHR_W+1:2] ^ ghr_spec;
    pht_rd     = pht[idx];
    head       = fifo[rd_ptr];
    res_ok     = res_valid && (count != '0) && (res_tag == rd_ptr);
    flush      = res_ok && res_mispredict;
    pred_ready = (count != FULL) && !(res_valid && res_mispredict);
    accept     = pred_req && pred_ready;
    ctr        = pht[head.pht_idx];
    ctr_next   = ctr;
    if (res_taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

  // Checkpoint payload needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= '{ghr_before: ghr_spec, pht_idx: idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_spec   <= '0;
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_tag   <= '0;
      res_error  <= 1'b0;
    end else begin
      pred_valid <= accept;
      if (accept) begin
        pred_taken <= pht_rd[1];
        pred_tag   <= wr_ptr;
        wr_ptr     <= wr_ptr + TAG_W'(1);
        ghr_spec   <= {ghr_spec[GHR_W-2:0], pht_rd[1]};
      end
      if (res_valid && !res_ok) res_error <= 1'b1;
      if (res_ok) begin
        pht[head.pht_idx] <= ctr_next;
        rd_ptr            <= rd_ptr + TAG_W'(1);
      end
      // A flush never coincides with an accept because pred_ready is low on any mispredict.
      if (flush) begin
        ghr_spec <= {head.ghr_before[GHR_W-2:0], res_taken};
        count    <= '0;
        wr_ptr   <= rd_ptr + TAG_W'(1);
      end else if (accept && !res_ok) begin
        count <= count + (TAG_W + 1)'(1);
      end else if (!accept && res_ok) begin
        count <= count - (TAG_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with hand-computed expectations (GHR_W=12, CKPT_DEPTH=8).
module tb_gshare_predictor;

  logic        clk;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [2:0]  pred_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic        res_mispredict;
  logic        res_error;

  int checks   = 0;
  int failures = 0;

  gshare_predictor #(.GHR_W(12), .CKPT_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_error(res_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    tick();
    pred_req = 1'b0;
  endtask

  task automatic do_res(input logic [2:0] tag, input logic taken, input logic mis);
    res_valid      = 1'b1;
    res_tag        = tag;
    res_taken      = taken;
    res_mispredict = mis;
    tick();
    res_valid      = 1'b0;
    res_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pred_req = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_mispredict = 1'b0;
    #12;
    check("rst_valid", 32'(pred_valid), 0);
    check("rst_taken", 32'(pred_taken), 0);
    check("rst_tag", 32'(pred_tag), 0);
    check("rst_err", 32'(res_error), 0);
    check("rst_ghr", 32'(dut.ghr_spec), 0);
    check("rst_pht", 32'(dut.pht[4]), 1);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(pred_ready), 1);

    // first prediction: idx 4, weakly not-taken
    do_req(32'h10);
    check("p1_valid", 32'(pred_valid), 1);
    check("p1_taken", 32'(pred_taken), 0);
    check("p1_tag", 32'(pred_tag), 0);
    check("p1_ghr", 32'(dut.ghr_spec), 0);
    tick();
    check("idle_valid", 32'(pred_valid), 0);
    check("idle_tag_hold", 32'(pred_tag), 0);

    // counter training at idx 4: 01 -> 10 -> 11 -> saturate
    do_res(3'd0, 1'b1, 1'b0);
    check("train1_pht", 32'(dut.pht[4]), 2);
    check("train1_count", 32'(dut.count), 0);
    do_req(32'h10);
    check("p2_taken", 32'(pred_taken), 1);
    check("p2_tag", 32'(pred_tag), 1);
    check("p2_ghr", 32'(dut.ghr_spec), 1);
    do_res(3'd1, 1'b1, 1'b0);
    check("train2_pht", 32'(dut.pht[4]), 3);
    do_req(32'h14);
    check("p3_taken", 32'(pred_taken), 1);
    check("p3_tag", 32'(pred_tag), 2);
    check("p3_ghr", 32'(dut.ghr_spec), 3);
    do_res(3'd2, 1'b1, 1'b0);
    check("sat_pht", 32'(dut.pht[4]), 3);

    // fill the checkpoint FIFO
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_req(32'h0);
      check($sformatf("fill_tag%0d", i), 32'(pred_tag), 32'(i));
    end
    check("full_ready", 32'(pred_ready), 0);
    check("full_count", 32'(dut.count), 8);
    pred_req = 1'b1;
    tick();
    pred_req = 1'b0;
    check("full_drop_valid", 32'(pred_valid), 0);
    check("full_drop_tag", 32'(pred_tag), 7);
    do_res(3'd0, 1'b0, 1'b0);
    check("unfull_ready", 32'(pred_ready), 1);
    check("unfull_count", 32'(dut.count), 7);
    check("dec_pht", 32'(dut.pht[0]), 0);
    // same-cycle resolve and accept; prediction reads the pre-update counter
    res_valid = 1'b1; res_tag = 3'd1; res_taken = 1'b1; res_mispredict = 1'b0;
    pred_req = 1'b1; pred_pc = 32'h0;
    tick();
    res_valid = 1'b0; pred_req = 1'b0;
    check("both_valid", 32'(pred_valid), 1);
    check("both_tag_wrap", 32'(pred_tag), 0);
    check("both_taken", 32'(pred_taken), 0);
    check("both_count", 32'(dut.count), 7);
    check("both_pht", 32'(dut.pht[0]), 1);

    // mispredict flush with a concurrent request
    do_reset();
    for (int i = 0; i < 3; i++) do_req(32'h0);
    check("pre_flush_tag", 32'(pred_tag), 2);
    res_valid = 1'b1; res_tag = 3'd0; res_taken = 1'b1; res_mispredict = 1'b1;
    pred_req = 1'b1; pred_pc = 32'h0;
    #1;
    check("flush_ready", 32'(pred_ready), 0);
    tick();
    res_valid = 1'b0; res_mispredict = 1'b0; pred_req = 1'b0;
    check("flush_valid", 32'(pred_valid), 0);
    check("flush_count", 32'(dut.count), 0);
    check("flush_ghr", 32'(dut.ghr_spec), 1);
    check("flush_pht", 32'(dut.pht[0]), 2);
    do_req(32'h0);
    check("post_flush_tag", 32'(pred_tag), 1);
    check("post_flush_taken", 32'(pred_taken), 0);
    check("post_flush_ghr", 32'(dut.ghr_spec), 2);

    // protocol violations
    do_reset();
    check("err_clear", 32'(res_error), 0);
    do_res(3'd0, 1'b0, 1'b0);
    check("err_empty", 32'(res_error), 1);
    check("err_empty_rd", 32'(dut.rd_ptr), 0);
    do_req(32'h0);
    check("err_req_tag", 32'(pred_tag), 0);
    do_res(3'd2, 1'b1, 1'b0);
    check("err_tag", 32'(res_error), 1);
    check("err_tag_count", 32'(dut.count), 1);
    check("err_tag_rd", 32'(dut.rd_ptr), 0);
    check("err_tag_pht", 32'(dut.pht[0]), 1);
    do_res(3'd0, 1'b1, 1'b0);
    check("err_sticky", 32'(res_error), 1);
    check("good_res_count", 32'(dut.count), 0);
    check("good_res_pht", 32'(dut.pht[0]), 2);

    // asynchronous reset between edges with five in flight
    do_req(32'h0);
    check("a1_taken", 32'(pred_taken), 1);
    check("a1_tag", 32'(pred_tag), 1);
    for (int i = 0; i < 4; i++) do_req(32'h0);
    check("pre_arst_count", 32'(dut.count), 5);
    check("pre_arst_ghr", 32'(dut.ghr_spec), 16);
    check("pre_arst_tag", 32'(pred_tag), 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_err", 32'(res_error), 0);
    check("arst_tag", 32'(pred_tag), 0);
    check("arst_ghr", 32'(dut.ghr_spec), 0);
    check("arst_count", 32'(dut.count), 0);
    check("arst_wr", 32'(dut.wr_ptr), 0);
    check("arst_pht", 32'(dut.pht[0]), 1);
    tick();
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(pred_ready), 1);
    do_req(32'h0);
    check("arst_first_tag", 32'(pred_tag), 0);
    check("arst_first_valid", 32'(pred_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
